// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute controller and its register file:
//   - 5-bit ALU opcode constants (ADD..ARSH)
//   - processor status flag bit positions inside the 5-bit {N,Z,F,L,C} word
//   - execute FSM state encoding
//   - small opcode classification helpers
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_CMP  = 5'd2;
   localparam logic [4:0] OP_AND  = 5'd3;
   localparam logic [4:0] OP_OR   = 5'd4;
   localparam logic [4:0] OP_XOR  = 5'd5;
   localparam logic [4:0] OP_NOT  = 5'd6;
   localparam logic [4:0] OP_LSH  = 5'd7;
   localparam logic [4:0] OP_RSH  = 5'd8;
   localparam logic [4:0] OP_ARSH = 5'd9;

   // Flag bit positions within the PSR / ALU flag word.
   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   // ST_ILLEGAL is the single cycle in which a rejected opcode is reported;
   // it never drives the ALU and never commits anything.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_OPERAND   = 3'd1,
      ST_EXEC      = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_ILLEGAL   = 3'd4
   } exec_state_t;

   function automatic logic op_is_legal(input logic [4:0] op);
      return (op <= OP_ARSH);
   endfunction

   // ADD/SUB take the whole flag word from the ALU.
   function automatic logic op_sets_all_flags(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Every legal op except CMP writes its result back to Rdest.
   function automatic logic op_writes_reg(input logic [4:0] op);
      return (op != OP_CMP);
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_reg_file.sv
// -----------------------------------------------------------------------------
// reg_file_16x16
// General register file of the execute controller.
//   clk, reset_n        : clock, asynchronous active-low clear of every entry
//   rd_a_addr/rd_a_data : combinational read port A (Rdest operand)
//   rd_b_addr/rd_b_data : combinational read port B (Rsrc operand)
//   dbg_addr/dbg_data   : combinational debug read port
//   wr_en/wr_addr/wr_data : synchronous write port
// -----------------------------------------------------------------------------
module reg_file_16x16 #(
   parameter  int DATA_W = 16,
   parameter  int NREGS  = 16,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [AW-1:0]     rd_a_addr,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [AW-1:0]     rd_b_addr,
   output logic [DATA_W-1:0] rd_b_data,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_a_data = mem_q[rd_a_addr];
   assign rd_b_data = mem_q[rd_b_addr];
   assign dbg_data  = mem_q[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
// Multi-cycle execute controller wrapped around an external combinational ALU.
// Owns the 16x16 register file and the PSR {N,Z,F,L,C}.
//
// Optional feature macro: IMM_EN (adds instr_imm / instr_use_imm; when
// use_imm is set the immediate replaces Rsrc for every op).
//
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   instr_valid/instr_ready  : instruction handshake
//   instr_op/rdest/rsrc      : opcode, destination/first operand, source index
//   instr_imm/instr_use_imm  : immediate operand and select (IMM_EN only)
//   alu_rdest/alu_rsrc/alu_opcode : ALU operands/opcode, zero outside EXEC
//   alu_out/alu_flags        : ALU result and flags
//   done / illegal           : one-cycle commit / reject pulses
//   flags                    : current PSR
//   dbg_addr/dbg_data        : combinational register read-back
//   dbg_state                : current FSM state
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE, and all instr_*
// inputs are ignored in every other state; valid may stay asserted and the
// next instruction is taken the cycle after WRITEBACK.
// -----------------------------------------------------------------------------
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int NREGS  = 16,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [4:0]        instr_op,
   input  logic [AW-1:0]     instr_rdest,
   input  logic [AW-1:0]     instr_rsrc,
`ifdef IMM_EN
   input  logic [DATA_W-1:0] instr_imm,
   input  logic              instr_use_imm,
`endif
   output logic [DATA_W-1:0] alu_rsrc,
   output logic [DATA_W-1:0] alu_rdest,
   output logic [4:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [4:0]        alu_flags,
   output logic              done,
   output logic              illegal,
   output logic [4:0]        flags,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [2:0]        dbg_state
);

   exec_state_t       state_q, state_d;
   logic [4:0]        op_q, op_d;
   logic [AW-1:0]     rdest_idx_q, rdest_idx_d;
   logic [AW-1:0]     rsrc_idx_q, rsrc_idx_d;
   logic [DATA_W-1:0] opa_q, opa_d;         // Rdest operand value
   logic [DATA_W-1:0] opb_q, opb_d;         // Rsrc (or immediate) operand value
   logic [DATA_W-1:0] res_q, res_d;         // captured ALU result
   logic [4:0]        rflags_q, rflags_d;   // captured ALU flags
   logic [4:0]        psr_q, psr_d;
`ifdef IMM_EN
   logic [DATA_W-1:0] imm_q, imm_d;
   logic              use_imm_q, use_imm_d;
`endif

   logic [DATA_W-1:0] rf_rd_a;
   logic [DATA_W-1:0] rf_rd_b;
   logic              rf_wr_en;

   // Both read ports are addressed by the latched indices, so rdest == rsrc
   // simply yields the same pre-instruction value on both operands.
   reg_file_16x16 #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_reg_file (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_a_addr (rdest_idx_q),
      .rd_a_data (rf_rd_a),
      .rd_b_addr (rsrc_idx_q),
      .rd_b_data (rf_rd_b),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .wr_en     (rf_wr_en),
      .wr_addr   (rdest_idx_q),
      .wr_data   (res_q)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rdest_idx_d = rdest_idx_q;
      rsrc_idx_d  = rsrc_idx_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      res_d       = res_q;
      rflags_d    = rflags_q;
      psr_d       = psr_q;
`ifdef IMM_EN
      imm_d       = imm_q;
      use_imm_d   = use_imm_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               op_d        = instr_op;
               rdest_idx_d = instr_rdest;
               rsrc_idx_d  = instr_rsrc;
`ifdef IMM_EN
               imm_d       = instr_imm;
               use_imm_d   = instr_use_imm;
`endif
               state_d     = ST_OPERAND;
            end
         end

         ST_OPERAND: begin
            opa_d = rf_rd_a;
`ifdef IMM_EN
            opb_d = use_imm_q ? imm_q : rf_rd_b;
`else
            opb_d = rf_rd_b;
`endif
            // Operand latching is harmless for a rejected op: nothing
            // downstream of ST_ILLEGAL consumes opa/opb.
            state_d = op_is_legal(op_q) ? ST_EXEC : ST_ILLEGAL;
         end

         ST_EXEC: begin
            res_d    = alu_out;
            rflags_d = alu_flags;
            state_d  = ST_WRITEBACK;
         end

         ST_WRITEBACK: begin
            if (op_sets_all_flags(op_q)) begin
               psr_d = rflags_q;
            end else if (op_q == OP_CMP) begin
               // Compare only refreshes the ordering flags; C and F keep
               // the last arithmetic result.
               psr_d[FLAG_L] = rflags_q[FLAG_L];
               psr_d[FLAG_Z] = rflags_q[FLAG_Z];
               psr_d[FLAG_N] = rflags_q[FLAG_N];
            end
            state_d = ST_IDLE;
         end

         ST_ILLEGAL: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         rdest_idx_q <= '0;
         rsrc_idx_q  <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         res_q       <= '0;
         rflags_q    <= '0;
         psr_q       <= '0;
`ifdef IMM_EN
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rdest_idx_q <= rdest_idx_d;
         rsrc_idx_q  <= rsrc_idx_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         res_q       <= res_d;
         rflags_q    <= rflags_d;
         psr_q       <= psr_d;
`ifdef IMM_EN
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
`endif
      end
   end

   // Register write happens on the WRITEBACK edge, so the new value shows up
   // on dbg_data the cycle after done.
   assign rf_wr_en = (state_q == ST_WRITEBACK) && op_writes_reg(op_q);

   // Outputs are decoded from the registered state only, so the pulses are
   // glitch-free and exactly one cycle wide.
   assign instr_ready = (state_q == ST_IDLE);
   assign done        = (state_q == ST_WRITEBACK);
   assign illegal     = (state_q == ST_ILLEGAL);
   assign flags       = psr_q;
   assign dbg_state   = state_q;

   assign alu_rdest   = (state_q == ST_EXEC) ? opa_q : '0;
   assign alu_rsrc    = (state_q == ST_EXEC) ? opb_q : '0;
   assign alu_opcode  = (state_q == ST_EXEC) ? op_q  : 5'd0;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
// Directed bench for alu_exec_ctrl. The bench plays the role of the external
// ALU: before each instruction it sets the result/flags the ALU would return,
// and checks the operands the controller presents during EXEC.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_exec_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  instr_op;
   logic [3:0]  instr_rdest;
   logic [3:0]  instr_rsrc;
`ifdef IMM_EN
   logic [15:0] instr_imm;
   logic        instr_use_imm;
`endif
   logic [15:0] alu_rsrc;
   logic [15:0] alu_rdest;
   logic [4:0]  alu_opcode;
   logic [15:0] alu_out;
   logic [4:0]  alu_flags;
   logic        done;
   logic        illegal;
   logic [4:0]  flags;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   alu_exec_ctrl dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_op      (instr_op),
      .instr_rdest   (instr_rdest),
      .instr_rsrc    (instr_rsrc),
`ifdef IMM_EN
      .instr_imm     (instr_imm),
      .instr_use_imm (instr_use_imm),
`endif
      .alu_rsrc      (alu_rsrc),
      .alu_rdest     (alu_rdest),
      .alu_opcode    (alu_opcode),
      .alu_out       (alu_out),
      .alu_flags     (alu_flags),
      .done          (done),
      .illegal       (illegal),
      .flags         (flags),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- driver ----------------
   // Issues one instruction and walks it through cycles 0..4, checking the
   // cycle-accurate protocol. exp_a/exp_b are the operands the ALU must see;
   // res/flg are what the stand-in ALU returns.
   task automatic run_instr(input string tag, input logic [4:0] op,
                            input logic [3:0] rd, input logic [3:0] rs,
                            input logic [15:0] exp_a, input logic [15:0] exp_b,
                            input logic [15:0] res, input logic [4:0] flg);
      alu_out   = res;
      alu_flags = flg;
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready: got %b want 1", tag, instr_ready);
      end
      instr_valid = 1'b1;
      instr_op    = op;
      instr_rdest = rd;
      instr_rsrc  = rs;
      @(negedge clk); // cycle 1: OPERAND; scramble inputs, they must be ignored
      instr_valid = 1'b0;
      instr_op    = 5'd31;
      instr_rdest = ~rd;
      instr_rsrc  = ~rs;
      checks++;
      if (alu_opcode !== 5'd0 || alu_rdest !== 16'h0 || alu_rsrc !== 16'h0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s_c1: alu op=%h a=%h b=%h done=%b want all 0", tag, alu_opcode, alu_rdest, alu_rsrc, done);
      end
      @(negedge clk); // cycle 2: EXEC
      checks++;
      if (alu_opcode !== op || alu_rdest !== exp_a || alu_rsrc !== exp_b) begin
         errors++;
         $display("FAIL %s_exec: op=%h a=%h b=%h want op=%h a=%h b=%h", tag, alu_opcode, alu_rdest, alu_rsrc, op, exp_a, exp_b);
      end
      @(negedge clk); // cycle 3: WRITEBACK
      checks++;
      if (done !== 1'b1 || instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_wb: done=%b ready=%b want done=1 ready=0", tag, done, instr_ready);
      end
      @(negedge clk); // cycle 4: IDLE again
      checks++;
      if (done !== 1'b0 || instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_idle: done=%b ready=%b want done=0 ready=1", tag, done, instr_ready);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         checks++;
         if (dbg_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_r%0d: got %h want 0000", i, dbg_data);
         end
      end
      checks++;
      if (flags !== 5'b00000 || instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: flags=%b ready=%b done=%b illegal=%b want 00000 1 0 0", flags, instr_ready, done, illegal);
      end
      checks++;
      if (alu_opcode !== 5'd0 || alu_rdest !== 16'h0 || alu_rsrc !== 16'h0 || dbg_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_alu: op=%h a=%h b=%h st=%0d want 0", alu_opcode, alu_rdest, alu_rsrc, dbg_state);
      end
   endtask

   // Registers are loaded with OR rX,rX where the stand-in ALU returns the
   // wanted value; the bogus all-ones flags must not reach the PSR.
   task automatic test_add;
      run_instr("ld_r1", OP_OR, 4'd1, 4'd1, 16'h0000, 16'h0000, 16'h7FFF, 5'b11111);
      run_instr("ld_r2", OP_OR, 4'd2, 4'd2, 16'h0000, 16'h0000, 16'h0001, 5'b11111);
      checks++;
      if (flags !== 5'b00000) begin
         errors++;
         $display("FAIL load_psr: got %b want 00000", flags);
      end
      // 0x7FFF + 1: N=1 Z=0 F=1 L=0 C=0
      run_instr("add", OP_ADD, 4'd1, 4'd2, 16'h7FFF, 16'h0001, 16'h8000, 5'b10100);
      dbg_addr = 4'd1;
      #1;
      checks++;
      if (dbg_data !== 16'h8000) begin
         errors++;
         $display("FAIL add_r1: got %h want 8000", dbg_data);
      end
      dbg_addr = 4'd2;
      #1;
      checks++;
      if (dbg_data !== 16'h0001) begin
         errors++;
         $display("FAIL add_r2: got %h want 0001", dbg_data);
      end
      checks++;
      if (flags !== 5'b10100) begin
         errors++;
         $display("FAIL add_psr: got %b want 10100", flags);
      end
   endtask

   task automatic test_cmp;
      run_instr("ld_r3", OP_OR, 4'd3, 4'd3, 16'h0000, 16'h0000, 16'h0005, 5'b11111);
      run_instr("ld_r4", OP_OR, 4'd4, 4'd4, 16'h0000, 16'h0000, 16'h0007, 5'b11111);
      // ALU reports N=1 Z=0 F=0 L=1 C=1; only N,Z,L may land, F=1 C=0 held.
      run_instr("cmp", OP_CMP, 4'd3, 4'd4, 16'h0005, 16'h0007, 16'hFFFE, 5'b10011);
      dbg_addr = 4'd3;
      #1;
      checks++;
      if (dbg_data !== 16'h0005) begin
         errors++;
         $display("FAIL cmp_r3: got %h want 0005", dbg_data);
      end
      checks++;
      if (flags !== 5'b10110) begin
         errors++;
         $display("FAIL cmp_psr: got %b want 10110", flags);
      end
   endtask

   task automatic test_sub_and;
      run_instr("ld_r5", OP_OR, 4'd5, 4'd5, 16'h0000, 16'h0000, 16'h1234, 5'b11111);
      // Same register on both sides: both operands 0x1234; Z=1 C=1.
      run_instr("sub", OP_SUB, 4'd5, 4'd5, 16'h1234, 16'h1234, 16'h0000, 5'b01001);
      dbg_addr = 4'd5;
      #1;
      checks++;
      if (dbg_data !== 16'h0000) begin
         errors++;
         $display("FAIL sub_r5: got %h want 0000", dbg_data);
      end
      checks++;
      if (flags !== 5'b01001) begin
         errors++;
         $display("FAIL sub_psr: got %b want 01001", flags);
      end
      run_instr("ld_r6", OP_OR, 4'd6, 4'd6, 16'h0000, 16'h0000, 16'h00F0, 5'b11111);
      run_instr("and", OP_AND, 4'd6, 4'd1, 16'h00F0, 16'h8000, 16'h0000, 5'b10110);
      dbg_addr = 4'd6;
      #1;
      checks++;
      if (dbg_data !== 16'h0000) begin
         errors++;
         $display("FAIL and_r6: got %h want 0000", dbg_data);
      end
      checks++;
      if (flags !== 5'b01001) begin
         errors++;
         $display("FAIL and_psr: got %b want 01001", flags);
      end
   endtask

   task automatic test_illegal;
      alu_out   = 16'hDEAD;
      alu_flags = 5'b11111;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op    = 5'd12;
      instr_rdest = 4'd1;
      instr_rsrc  = 4'd2;
      @(negedge clk); // cycle 1
      instr_valid = 1'b0;
      checks++;
      if (illegal !== 1'b0) begin
         errors++;
         $display("FAIL ill_c1: illegal=%b want 0", illegal);
      end
      @(negedge clk); // cycle 2
      checks++;
      if (illegal !== 1'b1 || done !== 1'b0 || alu_opcode !== 5'd0 || instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL ill_c2: illegal=%b done=%b aluop=%h ready=%b want 1 0 00 0", illegal, done, alu_opcode, instr_ready);
      end
      @(negedge clk); // cycle 3
      checks++;
      if (illegal !== 1'b0 || instr_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL ill_c3: illegal=%b ready=%b done=%b want 0 1 0", illegal, instr_ready, done);
      end
      dbg_addr = 4'd1;
      #1;
      checks++;
      if (dbg_data !== 16'h8000 || flags !== 5'b01001) begin
         errors++;
         $display("FAIL ill_state: r1=%h psr=%b want 8000 01001", dbg_data, flags);
      end
   endtask

   task automatic test_back_to_back;
      alu_out   = 16'hA5A5;
      alu_flags = 5'b11111;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op    = OP_XOR;
      instr_rdest = 4'd7;
      instr_rsrc  = 4'd7;
      @(negedge clk); // cycle 1: valid stays high with junk that must be ignored
      instr_op    = OP_OR;
      instr_rdest = 4'd9;
      instr_rsrc  = 4'd9;
      @(negedge clk); // cycle 2
      checks++;
      if (alu_opcode !== OP_XOR || alu_rdest !== 16'h0000 || alu_rsrc !== 16'h0000) begin
         errors++;
         $display("FAIL b2b_exec1: op=%h a=%h b=%h want 05 0000 0000", alu_opcode, alu_rdest, alu_rsrc);
      end
      @(negedge clk); // cycle 3: WRITEBACK, still not ready
      checks++;
      if (done !== 1'b1 || instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_wb1: done=%b ready=%b want 1 0", done, instr_ready);
      end
      instr_op    = OP_NOT;
      instr_rdest = 4'd8;
      instr_rsrc  = 4'd7;
      @(negedge clk); // cycle 4: IDLE, second instruction taken at next edge
      alu_out = 16'h5A5A;
      checks++;
      if (instr_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: ready=%b done=%b want 1 0", instr_ready, done);
      end
      dbg_addr = 4'd7;
      #1;
      checks++;
      if (dbg_data !== 16'hA5A5) begin
         errors++;
         $display("FAIL b2b_r7: got %h want a5a5", dbg_data);
      end
      @(negedge clk); // cycle 5
      instr_valid = 1'b0;
      @(negedge clk); // cycle 6
      checks++;
      if (alu_opcode !== OP_NOT || alu_rdest !== 16'h0000 || alu_rsrc !== 16'hA5A5) begin
         errors++;
         $display("FAIL b2b_exec2: op=%h a=%h b=%h want 06 0000 a5a5", alu_opcode, alu_rdest, alu_rsrc);
      end
      @(negedge clk); // cycle 7
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_wb2: done=%b want 1", done);
      end
      @(negedge clk); // cycle 8
      dbg_addr = 4'd8;
      #1;
      checks++;
      if (dbg_data !== 16'h5A5A) begin
         errors++;
         $display("FAIL b2b_r8: got %h want 5a5a", dbg_data);
      end
      dbg_addr = 4'd9;
      #1;
      checks++;
      if (dbg_data !== 16'h0000 || flags !== 5'b01001) begin
         errors++;
         $display("FAIL b2b_r9: r9=%h psr=%b want 0000 01001", dbg_data, flags);
      end
   endtask

   task automatic test_reset_abort;
      run_instr("ld_r10", OP_OR, 4'd10, 4'd10, 16'h0000, 16'h0000, 16'h8002, 5'b11111);
      alu_out   = 16'hC001;
      alu_flags = 5'b11111;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op    = OP_ARSH;
      instr_rdest = 4'd10;
      instr_rsrc  = 4'd2;
      @(negedge clk); // cycle 1
      instr_valid = 1'b0;
      @(negedge clk); // cycle 2: EXEC
      checks++;
      if (dbg_state !== 3'(ST_EXEC) || alu_rdest !== 16'h8002 || alu_rsrc !== 16'h0001) begin
         errors++;
         $display("FAIL abort_exec: st=%0d a=%h b=%h want 2 8002 0001", dbg_state, alu_rdest, alu_rsrc);
      end
      reset_n = 1'b0;
      #1;
      dbg_addr = 4'd10;
      #1;
      checks++;
      if (dbg_state !== 3'(ST_IDLE) || alu_opcode !== 5'd0 || done !== 1'b0 || flags !== 5'b00000 || dbg_data !== 16'h0000) begin
         errors++;
         $display("FAIL abort_async: st=%0d aluop=%h done=%b psr=%b r10=%h want 0 00 0 00000 0000", dbg_state, alu_opcode, done, flags, dbg_data);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_after%0d: done=%b ready=%b want 0 1", c, done, instr_ready);
         end
      end
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         checks++;
         if (dbg_data !== 16'h0000) begin
            errors++;
            $display("FAIL abort_r%0d: got %h want 0000", i, dbg_data);
         end
      end
      checks++;
      if (flags !== 5'b00000) begin
         errors++;
         $display("FAIL abort_psr: got %b want 00000", flags);
      end
   endtask

`ifdef IMM_EN
   task automatic test_imm;
      run_instr("ld_r1i", OP_OR, 4'd1, 4'd1, 16'h0000, 16'h0000, 16'h0001, 5'b11111);
      instr_imm     = 16'h0010;
      instr_use_imm = 1'b1;
      run_instr("add_imm", OP_ADD, 4'd1, 4'd2, 16'h0001, 16'h0010, 16'h0011, 5'b00000);
      instr_use_imm = 1'b0;
      dbg_addr = 4'd1;
      #1;
      checks++;
      if (dbg_data !== 16'h0011) begin
         errors++;
         $display("FAIL imm_r1: got %h want 0011", dbg_data);
      end
   endtask
`endif

   // ---------------- main sequence / report ----------------
   initial begin
      reset_n     = 1'b0;
      instr_valid = 1'b0;
      instr_op    = 5'd0;
      instr_rdest = 4'd0;
      instr_rsrc  = 4'd0;
`ifdef IMM_EN
      instr_imm     = 16'h0000;
      instr_use_imm = 1'b0;
`endif
      alu_out     = 16'h0000;
      alu_flags   = 5'b00000;
      dbg_addr    = 4'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      test_reset();
      test_add();
      test_cmp();
      test_sub_and();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
`ifdef IMM_EN
      test_imm();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
